// File: rtl/mqnic_app_tx_src_mac_rewrite.sv
// TX application stage: stamps the configured source MAC into bytes 6..11 of each
// outgoing frame and serves CTRL/FRAMES/REWRITES/CLEAR in the 0x0400-0x07FF window.
module mqnic_app_tx_src_mac_rewrite #(
  parameter int AXIS_DATA_WIDTH   = 512,
  parameter int AXIS_KEEP_WIDTH   = AXIS_DATA_WIDTH/8,
  parameter int AXIS_USER_WIDTH   = 1,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 16,
  parameter int STRB_WIDTH        = DATA_WIDTH/8,
  parameter int CONFIG_RAM_AWIDTH = 4,
  parameter int CONFIG_RAM_DWIDTH = 512
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0]   s_axis_tuser,

  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [AXIS_USER_WIDTH-1:0]   m_axis_tuser,

  output logic                         tx_config_ram_ren,
  output logic                         tx_config_ram_wen,
  output logic [CONFIG_RAM_AWIDTH-1:0] tx_config_ram_raddr,
  input  logic [CONFIG_RAM_DWIDTH-1:0] tx_config_ram_rdata,
  output logic [CONFIG_RAM_DWIDTH-1:0] tx_config_ram_wdata,

  input  logic [ADDR_WIDTH-1:0]        reg_wr_addr,
  input  logic [DATA_WIDTH-1:0]        reg_wr_data,
  input  logic [STRB_WIDTH-1:0]        reg_wr_strb,
  input  logic                         reg_wr_en,
  output logic                         reg_wr_wait,
  output logic                         reg_wr_ack,
  input  logic [ADDR_WIDTH-1:0]        reg_rd_addr,
  input  logic                         reg_rd_en,
  output logic [DATA_WIDTH-1:0]        reg_rd_data,
  output logic                         reg_rd_wait,
  output logic                         reg_rd_ack,

  output logic [1:0]                   dbg_state
);

  // Stream handshakes: a beat transfers on a rising clk edge where tvalid and tready
  // are both high; once raised, tvalid and the beat are held until that transfer.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_HEAD   = 2'd2,
    ST_BODY   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] mac_q;
  logic        rewrite_q;
  logic        ctrl_enable_q;
  logic [3:0]  ctrl_index_q;
  logic [31:0] frames_q;
  logic [31:0] rewrites_q;
  logic        in_hs;
  logic        out_last_hs;
  logic        wr_sel;
  logic        rd_sel;
  logic        clear_hit;

  assign in_hs       = s_axis_tvalid && s_axis_tready;
  assign out_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign dbg_state   = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (s_axis_tvalid) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_HEAD;
      ST_HEAD:   if (in_hs) state_d = s_axis_tlast ? ST_IDLE : ST_BODY;
      ST_BODY:   if (in_hs && s_axis_tlast) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready     = 1'b0;
    m_axis_tvalid     = 1'b0;
    tx_config_ram_ren = 1'b0;
    m_axis_tdata      = s_axis_tdata;
    case (state_q)
      ST_IDLE: tx_config_ram_ren = s_axis_tvalid && !rst;
      ST_HEAD: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (rewrite_q) m_axis_tdata[95:48] = mac_q;
      end
      ST_BODY: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign m_axis_tkeep = s_axis_tkeep;
  assign m_axis_tlast = s_axis_tlast;
  assign m_axis_tuser = s_axis_tuser;

  assign tx_config_ram_wen   = 1'b0;
  assign tx_config_ram_wdata = '0;
  assign tx_config_ram_raddr = CONFIG_RAM_AWIDTH'(ctrl_index_q);

  // RAM data arrives during LOOKUP; the rewrite decision is frozen for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_q     <= '0;
      rewrite_q <= 1'b0;
    end else if (state_q == ST_LOOKUP) begin
      mac_q     <= tx_config_ram_rdata[47:0];
      rewrite_q <= ctrl_enable_q && (s_axis_tkeep[11:6] == 6'h3F);
    end
  end

  assign reg_wr_wait = 1'b0;
  assign reg_rd_wait = 1'b0;
  assign wr_sel    = reg_wr_en && !reg_wr_ack && (reg_wr_addr[15:10] == 6'h01);
  assign rd_sel    = reg_rd_en && !reg_rd_ack && (reg_rd_addr[15:10] == 6'h01);
  assign clear_hit = wr_sel && (reg_wr_addr[9:2] == 8'h03);

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr_ack    <= 1'b0;
      reg_rd_ack    <= 1'b0;
      reg_rd_data   <= '0;
      ctrl_enable_q <= 1'b0;
      ctrl_index_q  <= '0;
    end else begin
      reg_wr_ack <= wr_sel;
      reg_rd_ack <= rd_sel;
      if (wr_sel && (reg_wr_addr[9:2] == 8'h00) && reg_wr_strb[0]) begin
        ctrl_enable_q <= reg_wr_data[0];
        ctrl_index_q  <= reg_wr_data[7:4];
      end
      reg_rd_data <= '0;
      if (rd_sel) begin
        case (reg_rd_addr[9:2])
          8'h00:   reg_rd_data <= DATA_WIDTH'({24'd0, ctrl_index_q, 3'd0, ctrl_enable_q});
          8'h01:   reg_rd_data <= DATA_WIDTH'(frames_q);
          8'h02:   reg_rd_data <= DATA_WIDTH'(rewrites_q);
          default: reg_rd_data <= '0;
        endcase
      end
    end
  end

  // A clear wins over an increment landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst || clear_hit) begin
      frames_q   <= '0;
      rewrites_q <= '0;
    end else if (out_last_hs) begin
      frames_q   <= frames_q + 32'd1;
      rewrites_q <= rewrites_q + 32'(rewrite_q);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{reg_wr_addr[1:0], reg_rd_addr[1:0], reg_wr_strb,
                         reg_wr_data[DATA_WIDTH-1:8], reg_wr_data[3:1],
                         tx_config_ram_rdata[CONFIG_RAM_DWIDTH-1:48]};

endmodule

// File: tb/tb_mqnic_app_tx_src_mac_rewrite.sv
// Bench for mqnic_app_tx_src_mac_rewrite: beat scoreboard, config RAM model,
// register accesses and reset-mid-frame recovery.
module tb_mqnic_app_tx_src_mac_rewrite;
  localparam int DW = 512;
  localparam int KW = DW/8;
  localparam int UW = 1;
  localparam int W  = DW + KW + 1 + UW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s_axis_tkeep, m_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [UW-1:0] s_axis_tuser, m_axis_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic          ren, wen;
  logic [3:0]    raddr;
  logic [511:0]  rdata, wdata;
  logic [15:0]   reg_wr_addr, reg_rd_addr;
  logic [31:0]   reg_wr_data, reg_rd_data;
  logic [3:0]    reg_wr_strb;
  logic          reg_wr_en, reg_wr_wait, reg_wr_ack;
  logic          reg_rd_en, reg_rd_wait, reg_rd_ack;
  logic [1:0]    dbg_state;

  mqnic_app_tx_src_mac_rewrite #(
    .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_USER_WIDTH(UW),
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4),
    .CONFIG_RAM_AWIDTH(4), .CONFIG_RAM_DWIDTH(512)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .tx_config_ram_ren(ren), .tx_config_ram_wen(wen), .tx_config_ram_raddr(raddr),
    .tx_config_ram_rdata(rdata), .tx_config_ram_wdata(wdata),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] exp_q[$];
  logic [511:0] ram [16];
  logic         exp_en = 1'b0;
  logic [3:0]   exp_idx = 4'd0;
  logic         bp_en = 1'b0;
  logic         mon_en = 1'b1;
  int           ren_count = 0;
  int           chk_cnt = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // backpressure source
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: config RAM model, bubble checks and scoreboard pops
  initial begin
    logic [W-1:0] e;
    rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (chk_cnt == 2) begin
          check("head_valid", m_axis_tvalid, 1);
          chk_cnt = 0;
        end
        if (chk_cnt == 1) begin
          check("lookup_bubble", {ren, m_axis_tvalid, s_axis_tready}, 0);
          chk_cnt = 2;
        end
        if (ren) begin
          ren_count++;
          check("ren_raddr", raddr, exp_idx);
          check("idle_bubble", {m_axis_tvalid, s_axis_tready}, 0);
          rdata = ram[raddr];
          chk_cnt = 1;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) check("extra_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, e);
          end
        end
      end
    end
  end

  // driver tasks: all start and end on a falling edge
  task automatic send_frame(input int nbeats, input logic [KW-1:0] keep0);
    logic [DW-1:0] d, ed;
    logic [KW-1:0] k;
    logic [47:0]   mac;
    logic          l;
    logic [UW-1:0] u;
    int            g;
    mac = ram[exp_idx][47:0];
    for (int b = 0; b < nbeats; b++) begin
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
      k  = (b == 0) ? keep0 : '1;
      l  = (b == nbeats - 1);
      u  = UW'($urandom_range(0, 1));
      ed = d;
      if (b == 0 && exp_en && keep0[11:6] == 6'h3F)
        for (int j = 0; j < 6; j++) ed[(6+j)*8 +: 8] = mac[j*8 +: 8];
      exp_q.push_back({ed, k, l, u});
      s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
      s_axis_tvalid = 1'b1;
      g = 0;
      #1;
      while (!s_axis_tready && g < 500) begin
        @(negedge clk); #1; g++;
      end
      if (g >= 500) check("hs_timeout", 0, 1);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    reg_wr_addr = a; reg_wr_data = d; reg_wr_strb = s; reg_wr_en = 1'b1;
    @(negedge clk);
    reg_wr_en = 1'b0;
    #1 check("wr_ack", reg_wr_ack, 1);
    @(negedge clk);
  endtask

  task automatic reg_read(input logic [15:0] a, input logic [31:0] exp, input string tag);
    reg_rd_addr = a; reg_rd_en = 1'b1;
    @(negedge clk);
    reg_rd_en = 1'b0;
    #1;
    check({tag, "_ack"}, reg_rd_ack, 1);
    check(tag, reg_rd_data, exp);
    @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk); g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int g;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) ram[i][j*32 +: 32] = $urandom();
    end
    ram[1][47:0] = 48'h665544332211;
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; s_axis_tuser = '0;
    reg_wr_addr = '0; reg_wr_data = '0; reg_wr_strb = '0; reg_wr_en = 1'b0;
    reg_rd_addr = '0; reg_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_ren_wen", {ren, wen}, 0);
    check("rst_acks", {reg_wr_ack, reg_rd_ack}, 0);
    check("rst_rd_data", reg_rd_data, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);
    reg_read(16'h0400, 32'h0, "rst_ctrl");
    reg_read(16'h0404, 32'h0, "rst_frames");
    reg_read(16'h0408, 32'h0, "rst_rewrites");

    // enabled rewrite of a 64-byte frame
    reg_write(16'h0400, 32'h11, 4'h1);
    exp_en = 1'b1; exp_idx = 4'd1;
    reg_read(16'h0400, 32'h11, "ctrl");
    send_frame(1, '1);
    drain();
    reg_read(16'h0404, 32'd1, "frames_1");
    reg_read(16'h0408, 32'd1, "rewrites_1");

    // disabled: pass-through
    reg_write(16'h0400, 32'h10, 4'h1);
    exp_en = 1'b0;
    send_frame(1, '1);
    drain();
    reg_read(16'h0404, 32'd2, "frames_2");
    reg_read(16'h0408, 32'd1, "rewrites_2");

    // enabled but first beat too short to hold the source MAC
    reg_write(16'h0400, 32'h21, 4'h1);
    exp_en = 1'b1; exp_idx = 4'd2;
    send_frame(1, KW'(16'h03FF));
    drain();
    reg_read(16'h0404, 32'd3, "frames_3");
    reg_read(16'h0408, 32'd1, "rewrites_3");

    // strobe-off write and unmapped write leave CTRL untouched
    reg_write(16'h0400, 32'hF0, 4'h0);
    reg_write(16'h0414, 32'hF0, 4'hF);
    reg_read(16'h0400, 32'h21, "ctrl_strb");

    // back-to-back 3-beat frames under backpressure
    bp_en = 1'b1;
    ren_count = 0;
    for (int f = 0; f < 3; f++) send_frame(3, '1);
    drain();
    bp_en = 1'b0;
    check("ren_per_frame", ren_count, 3);
    reg_read(16'h0404, 32'd6, "frames_6");
    reg_read(16'h0408, 32'd4, "rewrites_4");

    // unmapped/WO reads, out-of-window read, en held across ack
    reg_read(16'h0410, 32'h0, "unmapped_rd");
    reg_read(16'h040C, 32'h0, "clear_rd");
    reg_rd_addr = 16'h0800; reg_rd_en = 1'b1;
    @(negedge clk);
    reg_rd_en = 1'b0;
    #1 check("oow_no_ack", reg_rd_ack, 0);
    @(negedge clk);
    reg_rd_addr = 16'h0404; reg_rd_en = 1'b1;
    @(negedge clk);
    #1 check("held_ack_1", reg_rd_ack, 1);
    @(negedge clk);
    reg_rd_en = 1'b0;
    #1 check("held_ack_2", reg_rd_ack, 0);
    @(negedge clk);

    // clear landing on the same edge as a frame's tlast handshake
    fork
      send_frame(1, '1);
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk); #1;
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) break;
        end
        reg_wr_addr = 16'h040C; reg_wr_data = 32'h1; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
        @(negedge clk);
        reg_wr_en = 1'b0;
        #1 check("clear_ack", reg_wr_ack, 1);
      end
    join
    @(negedge clk);
    drain();
    reg_read(16'h0404, 32'd0, "frames_clr");
    reg_read(16'h0408, 32'd0, "rewrites_clr");
    send_frame(1, '1);
    drain();
    reg_read(16'h0404, 32'd1, "frames_after_clr");

    // reset while in BODY
    mon_en = 1'b0;
    s_axis_tdata = '1; s_axis_tkeep = '1; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    g = 0;
    #1;
    while (!s_axis_tready && g < 20) begin
      @(negedge clk); #1; g++;
    end
    check("rst_reach_head", dbg_state, 2);
    @(negedge clk);
    #1 check("rst_in_body", dbg_state, 3);
    rst = 1'b1; s_axis_tvalid = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_state", dbg_state, 0);
    check("midrst_s_tready", s_axis_tready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    reg_read(16'h0400, 32'h0, "midrst_ctrl");
    reg_read(16'h0404, 32'h0, "midrst_frames");
    reg_read(16'h0408, 32'h0, "midrst_rewrites");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
